// File: rtl/bp_cfg_stream_loader.sv
// rtl/bp_cfg_stream_loader.sv - streams a config register table to one or all cores
module bp_cfg_stream_loader #(
  parameter int num_cores_p      = 1,
  parameter int num_regs_p       = 16,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  localparam int core_id_width_lp = (num_cores_p == 1) ? 1 : $clog2(num_cores_p),
  localparam int idx_width_lp     = (num_regs_p == 1) ? 1 : $clog2(num_regs_p),
  localparam int cnt_width_lp     = ((num_cores_p * num_regs_p + 1) == 1) ? 1
                                    : $clog2(num_cores_p * num_regs_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        bcast_i,
  output logic [idx_width_lp-1:0]     tbl_idx_o,
  input  logic                        tbl_v_i,
  input  logic [cfg_addr_width_p-1:0] tbl_addr_i,
  input  logic [cfg_data_width_p-1:0] tbl_data_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_lp-1:0] cfg_core_id_o,
  output logic                        cfg_bcast_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [cnt_width_lp-1:0]     sent_cnt_o
);

  localparam logic [idx_width_lp-1:0]     last_idx_lp  = idx_width_lp'(num_regs_p - 1);
  localparam logic [core_id_width_lp-1:0] last_core_lp = core_id_width_lp'(num_cores_p - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e                      state_r;
  logic [core_id_width_lp-1:0] core_r;
  logic [idx_width_lp-1:0]     idx_r;
  logic                        bcast_r;
  logic [cnt_width_lp-1:0]     sent_cnt_r;
  logic                        busy_r;
  logic                        done_r;

  logic in_send;
  logic accept;
  logic advance;
  logic last_entry;

  // Payload is taken straight from the table ROM; it stays stable during a
  // stall because the ROM index only moves on an advance.
  assign in_send       = (state_r == SEND);
  assign cfg_v_o       = in_send & tbl_v_i;
  assign accept        = cfg_v_o & cfg_ready_i;
  assign advance       = in_send & (~tbl_v_i | cfg_ready_i);
  assign last_entry    = (idx_r == last_idx_lp) & (bcast_r | (core_r == last_core_lp));
  assign tbl_idx_o     = idx_r;
  assign cfg_core_id_o = bcast_r ? '0 : core_r;
  assign cfg_bcast_o   = bcast_r;
  assign cfg_addr_o    = tbl_addr_i;
  assign cfg_data_o    = tbl_data_i;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign sent_cnt_o    = sent_cnt_r;

  // Sequencer: walks core-major over the table, skipping invalid entries in one cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      core_r     <= '0;
      idx_r      <= '0;
      bcast_r    <= 1'b0;
      sent_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            state_r    <= SEND;
            bcast_r    <= bcast_i;
            core_r     <= '0;
            idx_r      <= '0;
            sent_cnt_r <= '0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end
        end
        SEND: begin
          if (accept) begin
            sent_cnt_r <= sent_cnt_r + cnt_width_lp'(1);
          end
          if (advance) begin
            if (last_entry) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              idx_r   <= '0;
              core_r  <= '0;
            end else if (idx_r != last_idx_lp) begin
              idx_r <= idx_r + idx_width_lp'(1);
            end else begin
              idx_r  <= '0;
              core_r <= core_r + core_id_width_lp'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_stream_loader.sv
// tb/tb_bp_cfg_stream_loader.sv - scoreboard bench for bp_cfg_stream_loader
module tb_bp_cfg_stream_loader;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic        bcast_i;
  logic [1:0]  tbl_idx_o;
  logic        tbl_v_i;
  logic [15:0] tbl_addr_i;
  logic [63:0] tbl_data_i;
  logic        cfg_v_o;
  logic        cfg_ready_i;
  logic [0:0]  cfg_core_id_o;
  logic        cfg_bcast_o;
  logic [15:0] cfg_addr_o;
  logic [63:0] cfg_data_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  sent_cnt_o;

  logic [3:0]   valid_mask;
  logic [127:0] exp_q[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  always #5 clk_i = ~clk_i;

  bp_cfg_stream_loader #(
    .num_cores_p(2), .num_regs_p(4), .cfg_addr_width_p(16), .cfg_data_width_p(64)
  ) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .bcast_i(bcast_i),
    .tbl_idx_o(tbl_idx_o), .tbl_v_i(tbl_v_i), .tbl_addr_i(tbl_addr_i),
    .tbl_data_i(tbl_data_i), .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i),
    .cfg_core_id_o(cfg_core_id_o), .cfg_bcast_o(cfg_bcast_o), .cfg_addr_o(cfg_addr_o),
    .cfg_data_o(cfg_data_o), .busy_o(busy_o), .done_o(done_o), .sent_cnt_o(sent_cnt_o)
  );

  // Table ROM model
  assign tbl_v_i    = valid_mask[tbl_idx_o];
  assign tbl_addr_i = 16'h0100 + {14'b0, tbl_idx_o};
  assign tbl_data_i = {48'hC0DE_F00D_0000, 14'b0, tbl_idx_o};

  function automatic logic [127:0] beat(input int core, input logic b, input int idx);
    logic [15:0] a;
    logic [63:0] d;
    a = 16'h0100 + 16'(idx);
    d = 64'hC0DE_F00D_0000_0000 | 64'(idx);
    return {46'b0, 1'(core), b, a, d};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard: compare every accepted beat against the oldest expected one
  always @(negedge clk_i) begin
    if (reset_n_i && cfg_v_o && cfg_ready_i) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", {46'b0, cfg_core_id_o, cfg_bcast_o, cfg_addr_o, cfg_data_o}, 128'h0);
      end else begin
        check("beat", {46'b0, cfg_core_id_o, cfg_bcast_o, cfg_addr_o, cfg_data_o}, exp_q.pop_front());
      end
    end
  end

  task automatic push_seq(input logic b);
    for (int c = 0; c < (b ? 1 : 2); c++)
      for (int i = 0; i < 4; i++)
        if (valid_mask[i]) exp_q.push_back(beat(c, b, i));
  endtask

  task automatic pulse_start(input logic b);
    bcast_i = b;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_o && cycles < 60) begin
      @(posedge clk_i); #1;
      cycles++;
    end
  endtask

  task automatic run_seq(input string tag, input logic b, input logic [3:0] mask,
                         input int exp_cycles, input int exp_sent);
    int cyc;
    valid_mask = mask;
    push_seq(b);
    pulse_start(b);
    check({tag, "_busy"}, 128'(busy_o), 128'(1));
    wait_done(cyc);
    check({tag, "_cycles"}, 128'(cyc), 128'(exp_cycles));
    check({tag, "_done"}, 128'(done_o), 128'(1));
    check({tag, "_sent"}, 128'(sent_cnt_o), 128'(exp_sent));
    check({tag, "_queue_left"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    reset_n_i = 1'b0; start_i = 1'b0; bcast_i = 1'b0; cfg_ready_i = 1'b1; valid_mask = 4'hF;
    #1;
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_cfg_v", 128'(cfg_v_o), 128'(0));
    check("rst_sent", 128'(sent_cnt_o), 128'(0));
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("idle_busy", 128'(busy_o), 128'(0));
    check("idle_done", 128'(done_o), 128'(0));
    check("idle_idx", 128'(tbl_idx_o), 128'(0));

    run_seq("unicast", 1'b0, 4'hF, 8, 8);
    repeat (3) @(posedge clk_i);
    #1;
    check("done_hold", 128'(done_o), 128'(1));
    check("sent_hold", 128'(sent_cnt_o), 128'(8));

    // restart from DONE
    valid_mask = 4'hF;
    push_seq(1'b0);
    pulse_start(1'b0);
    check("restart_done", 128'(done_o), 128'(0));
    check("restart_sent", 128'(sent_cnt_o), 128'(0));
    wait_done(cyc);
    check("restart_cycles", 128'(cyc), 128'(8));
    check("restart_total", 128'(sent_cnt_o), 128'(8));
    check("restart_queue", 128'(exp_q.size()), 128'(0));
    exp_q.delete();

    // broadcast, with start held high during SEND to show it is ignored
    valid_mask = 4'hF;
    push_seq(1'b1);
    pulse_start(1'b1);
    start_i = 1'b1; bcast_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(cyc);
    check("bcast_cycles", 128'(cyc + 1), 128'(4));
    check("bcast_sent", 128'(sent_cnt_o), 128'(4));
    check("bcast_queue", 128'(exp_q.size()), 128'(0));
    exp_q.delete();

    run_seq("skip12", 1'b0, 4'b1001, 8, 4);
    run_seq("skip12_bc", 1'b1, 4'b1001, 4, 2);
    run_seq("all_invalid", 1'b0, 4'b0000, 8, 0);
    run_seq("all_invalid_bc", 1'b1, 4'b0000, 4, 0);

    // stall on first beat for 5 cycles
    valid_mask = 4'hF;
    cfg_ready_i = 1'b0;
    push_seq(1'b0);
    pulse_start(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      check("stall_v", 128'(cfg_v_o), 128'(1));
      check("stall_payload", {46'b0, cfg_core_id_o, cfg_bcast_o, cfg_addr_o, cfg_data_o}, beat(0, 1'b0, 0));
      @(posedge clk_i); #1;
    end
    check("stall_sent0", 128'(sent_cnt_o), 128'(0));
    cfg_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("stall_sent1", 128'(sent_cnt_o), 128'(1));
    wait_done(cyc);
    check("stall_total", 128'(sent_cnt_o), 128'(8));
    check("stall_queue", 128'(exp_q.size()), 128'(0));
    exp_q.delete();

    // reset in the middle of a stalled beat
    cfg_ready_i = 1'b0;
    pulse_start(1'b0);
    @(posedge clk_i); #1;
    check("pre_rst_v", 128'(cfg_v_o), 128'(1));
    #2 reset_n_i = 1'b0;
    #1;
    check("midrst_v", 128'(cfg_v_o), 128'(0));
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_sent", 128'(sent_cnt_o), 128'(0));
    check("midrst_idx", 128'(tbl_idx_o), 128'(0));
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    cfg_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("postrst_busy", 128'(busy_o), 128'(0));
    check("postrst_done", 128'(done_o), 128'(0));
    run_seq("after_rst", 1'b0, 4'hF, 8, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bp_cfg_stream_loader.md
BP_CFG_STREAM_LOADER -- requirements
Module: bp_cfg_stream_loader

Interface
REQ-001 SHALL have parameter num_cores_p, default 1: number of core config targets (cc_x_dim*cc_y_dim), legal range 1..64.
REQ-002 SHALL have parameter num_regs_p, default 16: config table entries per pass, legal range 1..256.
REQ-003 SHALL have parameter cfg_addr_width_p, default 16: config register address width.
REQ-004 SHALL have parameter cfg_data_width_p, default 64: config register data width.
REQ-005 SHALL derive core_id_width_lp = BSG_SAFE_CLOG2(num_cores_p), idx_width_lp = BSG_SAFE_CLOG2(num_regs_p) and cnt_width_lp = BSG_SAFE_CLOG2(num_cores_p*num_regs_p+1).
REQ-006 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-007 reset_n_i  in  1  asynchronous, active-low reset.
REQ-008 start_i  in  1  begin a load sequence; sampled only in IDLE or DONE.
REQ-009 bcast_i  in  1  broadcast mode; sampled together with start_i.
REQ-010 tbl_idx_o  out  idx_width_lp  table read index, combinational ROM.
REQ-011 tbl_v_i / tbl_addr_i / tbl_data_i  in  1 / cfg_addr_width_p / cfg_data_width_p  entry valid, address and data at tbl_idx_o, same cycle.
REQ-012 cfg_v_o  out  1  config beat valid.
REQ-013 cfg_ready_i  in  1  downstream accepts the beat.
REQ-014 cfg_core_id_o / cfg_bcast_o / cfg_addr_o / cfg_data_o  out  core_id_width_lp / 1 / cfg_addr_width_p / cfg_data_width_p  beat payload.
REQ-015 busy_o / done_o  out  1 / 1  sequence in progress / sequence complete.
REQ-016 sent_cnt_o  out  cnt_width_lp  accepted beats in the current or last sequence.

Function
REQ-017 SHALL implement FSM states IDLE, SEND and DONE.
REQ-018 IDLE or DONE with start_i=1: latch bcast_i into bcast_r, clear core_r, idx_r and sent_cnt_o, and enter SEND on the next edge.
REQ-019 busy_o SHALL be 1 exactly in SEND; done_o SHALL be 1 exactly in DONE, held until start_i or reset.
REQ-020 tbl_idx_o SHALL equal idx_r in every state.
REQ-021 In SEND with tbl_v_i=1: cfg_v_o=1, cfg_addr_o=tbl_addr_i, cfg_data_o=tbl_data_i, cfg_core_id_o=core_r (0 when bcast_r=1), cfg_bcast_o=bcast_r.
REQ-022 In SEND with tbl_v_i=0: cfg_v_o=0 and the entry is skipped (advance) in that cycle; a skip takes one cycle.
REQ-023 Handshake: a beat is accepted when cfg_v_o & cfg_ready_i; on acceptance sent_cnt_o increments by 1 and the FSM advances.
REQ-024 While cfg_v_o=1 and cfg_ready_i=0, payload and indices SHALL hold stable; valid is never withdrawn.
REQ-025 Advance: if idx_r<num_regs_p-1, increment idx_r; otherwise set idx_r=0 and increment core_r.
REQ-026 The last entry is idx_r=num_regs_p-1 with core_r=num_cores_p-1, or with any core_r when bcast_r=1; advancing from it enters DONE.
REQ-027 Ordering SHALL be core-major: all regs of core 0, then core 1, and so on; broadcast performs exactly one pass.
REQ-028 cfg_ready_i asserted while cfg_v_o=0 SHALL have no effect.
REQ-029 start_i in SEND SHALL be ignored.
REQ-030 A table with all tbl_v_i=0 SHALL reach DONE after num_cores_p*num_regs_p SEND cycles (num_regs_p if broadcast) with sent_cnt_o=0.
REQ-031 sent_cnt_o SHALL hold its value in DONE and IDLE until the next start_i.
REQ-032 Single-register, single-core case (num_regs_p=1, num_cores_p=1) SHALL function, with one beat then DONE.

Reset
REQ-033 reset_n_i=0 SHALL immediately and asynchronously force IDLE, cfg_v_o=0, busy_o=0, done_o=0, sent_cnt_o=0, core_r=0, idx_r=0 and bcast_r=0, including mid-SEND with a beat stalled.
REQ-034 After reset_n_i deasserts, the block SHALL remain in IDLE until start_i.

Verification
REQ-035 Setup num_cores_p=2, num_regs_p=4, all entries valid, cfg_ready_i=1, start_i pulse -> 8 beats on consecutive cycles in order (core0 idx0..3, core1 idx0..3), then done_o=1 and sent_cnt_o=8.
REQ-036 Same setup with bcast_i=1 -> 4 beats with cfg_bcast_o=1 and cfg_core_id_o=0, then DONE with sent_cnt_o=4.
REQ-037 Entries 1 and 2 invalid, num_cores_p=1 -> beats for idx 0 and 3 only, DONE after 4 SEND cycles, sent_cnt_o=2.
REQ-038 cfg_ready_i=0 for 5 cycles on the first beat -> cfg_v_o=1 with identical payload for 5 cycles, accepted on cycle 6, sent_cnt_o=1.
REQ-039 reset_n_i low mid-stall -> cfg_v_o=0 in the same cycle; after release, state IDLE, sent_cnt_o=0, and a new start_i restarts at core 0 idx 0.
REQ-040 start_i asserted in DONE -> sent_cnt_o clears, done_o=0 next cycle, and the sequence repeats identically.
